// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, handshakes with the instruction ROM and queues
// fetched words for IF/ID. Define IF_PERF_CNT_EN to add the if_bubble_cnt empty-queue counter.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_romReq,
    output logic [31:0] o_romAddr,
    input  logic        i_romAck,
    input  logic [31:0] i_romInst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] if_bubble_cnt
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_rom_req, w_req_nxt;
    logic [31:0]        r_rom_addr, w_addr_nxt;
    logic [31:0]        r_fetch_pc, w_pc_nxt;
    logic [31:0]        w_pc_inc, w_br_pc;
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               w_push, w_pop;
    logic [31:0]        r_q_pc   [FIFO_DEPTH];
    logic [31:0]        r_q_inst [FIFO_DEPTH];
    logic               w_unused;

    assign w_unused = &{1'b0, br_target[1:0]};
    assign w_br_pc  = {br_target[31:2], 2'b00};
    assign w_pc_inc = r_fetch_pc + 32'd4;

    // Only a live request in REQ may deliver data; DROP and IDLE acks are discarded.
    assign w_push = (r_state == S_REQ) && i_romAck && !br_taken;
    assign w_pop  = if_valid && !id_stall && !br_taken;
    assign w_count_nxt = br_taken ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));

    assign if_valid  = (r_count != '0);
    assign if_pc     = if_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
    assign if_inst   = if_valid ? r_q_inst[r_rd_ptr] : 32'h0;
    assign o_romReq  = r_rom_req;
    assign o_romAddr = r_rom_addr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_req_nxt   = r_rom_req;
        w_addr_nxt  = r_rom_addr;
        w_pc_nxt    = r_fetch_pc;
        if (br_taken) begin
            w_pc_nxt = w_br_pc;
            if (r_rom_req && !i_romAck) begin
                w_state_nxt = S_DROP;
            end else begin
                w_state_nxt = S_REQ;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = w_br_pc;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < DEPTH_C) begin
                        w_state_nxt = S_REQ;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (i_romAck) begin
                        w_pc_nxt = w_pc_inc;
                        if (w_count_nxt < DEPTH_C) begin
                            w_addr_nxt = w_pc_inc;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_req_nxt   = 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (i_romAck) begin
                        w_state_nxt = S_REQ;
                        w_addr_nxt  = r_fetch_pc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rom_req  <= 1'b0;
            r_rom_addr <= 32'h0;
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rom_req  <= w_req_nxt;
            r_rom_addr <= w_addr_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_count    <= w_count_nxt;
            if (br_taken) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            end
        end
    end

    // NOTE: queue storage has no reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_rom_addr;
            r_q_inst[r_wr_ptr] <= i_romInst;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= 32'h0;
        end else if (!if_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign if_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, stall back-pressure, redirects,
// PC wrap (second instance at RESET_PC=0xFFFF_FFF8) and asynchronous reset.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic        id_stall, br_taken;
    logic [31:0] br_target;

    logic        o_romReq, i_romAck, if_valid;
    logic [31:0] o_romAddr, i_romInst, if_pc, if_inst;
    logic        o_romReq2, i_romAck2, if_valid2;
    logic [31:0] o_romAddr2, i_romInst2, if_pc2, if_inst2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] if_bubble_cnt, if_bubble_cnt2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_unit u_dut (
        .clk(clk), .rst(rst),
        .o_romReq(o_romReq), .o_romAddr(o_romAddr),
        .i_romAck(i_romAck), .i_romInst(i_romInst),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target)
`ifdef IF_PERF_CNT_EN
        , .if_bubble_cnt(if_bubble_cnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .o_romReq(o_romReq2), .o_romAddr(o_romAddr2),
        .i_romAck(i_romAck2), .i_romInst(i_romInst2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_inst(if_inst2),
        .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target)
`ifdef IF_PERF_CNT_EN
        , .if_bubble_cnt(if_bubble_cnt2)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Zero-wait ROM: acks in the same cycle the registered request is visible.
    task automatic rom_drive();
        i_romAck   = rom_en && o_romReq;
        i_romInst  = i_romAck ? inst_of(o_romAddr) : 32'h0;
        i_romAck2  = rom_en && o_romReq2;
        i_romInst2 = i_romAck2 ? inst_of(o_romAddr2) : 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        rom_drive();
    endtask

    initial begin
        rst = 1'b1; rom_en = 1'b1; id_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        i_romAck = 1'b0; i_romInst = 32'h0; i_romAck2 = 1'b0; i_romInst2 = 32'h0;
        #1 rst = 1'b0;
        #2;
        check("rst_req", o_romReq, 1'b0);
        check("rst_addr", o_romAddr, 32'h0);
        check("rst_valid", if_valid, 1'b0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        @(negedge clk);
        check("rst_hold_req", o_romReq, 1'b0);
        rst = 1'b1;
        rom_drive();

        // Sequential fetch after reset release.
        cycle();
        check("seq_req0", o_romReq, 1'b1);
        check("seq_addr0", o_romAddr, 32'h0);
        check("seq_valid0", if_valid, 1'b0);
        check("wrap_addr0", o_romAddr2, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc, exp_pc2;
            exp_pc  = 32'(i * 4);
            exp_pc2 = 32'hFFFF_FFF8 + 32'(i * 4);
            cycle();
            check("seq_valid", if_valid, 1'b1);
            check("seq_pc", if_pc, exp_pc);
            check("seq_inst", if_inst, inst_of(exp_pc));
            check("seq_addr", o_romAddr, exp_pc + 32'd4);
            check("wrap_pc", if_pc2, exp_pc2);
            check("wrap_addr", o_romAddr2, exp_pc2 + 32'd4);
        end
        check("wrap_inst", if_inst2, inst_of(32'h0));

        // Stall: queue fills to two entries and the request is dropped.
        id_stall = 1'b1;
        cycle();
        check("stall_req_drop", o_romReq, 1'b0);
        check("stall_head0", if_pc, 32'h8);
        repeat (5) cycle();
        check("stall_req_idle", o_romReq, 1'b0);
        check("stall_valid", if_valid, 1'b1);
        check("stall_head_held", if_pc, 32'h8);
        id_stall = 1'b0;
        cycle();
        check("drain_head1", if_pc, 32'hC);
        check("drain_inst1", if_inst, inst_of(32'hC));
        cycle();
        check("drain_empty", if_valid, 1'b0);
        check("resume_req", o_romReq, 1'b1);
        check("resume_addr", o_romAddr, 32'h10);
        cycle();
        check("resume_pc", if_pc, 32'h10);
        check("resume_inst", if_inst, inst_of(32'h10));

        // Redirect with a request outstanding and no ack: old request held, data dropped.
        rom_en = 1'b0;
        rom_drive();
        cycle();
        check("pre_br_valid", if_valid, 1'b0);
        check("pre_br_addr", o_romAddr, 32'h14);
        br_taken = 1'b1; br_target = 32'h0000_0103;
        cycle();
        br_taken = 1'b0;
        check("drop_req", o_romReq, 1'b1);
        check("drop_addr", o_romAddr, 32'h14);
        cycle();
        check("drop_hold_addr", o_romAddr, 32'h14);
        check("drop_valid", if_valid, 1'b0);
        rom_en = 1'b1;
        rom_drive();
        cycle();
        check("drop_done_addr", o_romAddr, 32'h100);
        check("drop_done_valid", if_valid, 1'b0);
        cycle();
        check("br_first_valid", if_valid, 1'b1);
        check("br_first_pc", if_pc, 32'h100);
        check("br_first_inst", if_inst, inst_of(32'h100));

        // Redirect coinciding with an ack and an active pop.
        br_taken = 1'b1; br_target = 32'h0000_0200;
        cycle();
        br_taken = 1'b0;
        check("br_ack_valid", if_valid, 1'b0);
        check("br_ack_req", o_romReq, 1'b1);
        check("br_ack_addr", o_romAddr, 32'h200);
        cycle();
        check("br_ack_pc", if_pc, 32'h200);
        check("br_ack_inst", if_inst, inst_of(32'h200));

        // Asynchronous reset mid-REQ, then a late ack that must be ignored.
        #2 rst = 1'b0;
        #1;
        check("arst_req", o_romReq, 1'b0);
        check("arst_valid", if_valid, 1'b0);
        check("arst_addr", o_romAddr, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("arst_bubble", if_bubble_cnt, 32'h0);
`endif
        rom_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i_romAck = 1'b1; i_romInst = 32'hDEAD_BEEF;
        i_romAck2 = 1'b1; i_romInst2 = 32'hDEAD_BEEF;
        cycle();
        cycle();
        cycle();
        check("late_ack_valid", if_valid, 1'b0);
        check("post_rst_req", o_romReq, 1'b1);
        check("post_rst_addr", o_romAddr, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("bubble_cnt", if_bubble_cnt, 32'd3);
`endif
        rom_en = 1'b1;
        rom_drive();
        cycle();
        check("post_rst_pc", if_pc, 32'h0);
        check("post_rst_inst", if_inst, inst_of(32'h0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage and producer side of the IF/ID pipeline register.
- Owns the fetch PC and runs a request/acknowledge handshake with the instruction ROM.
- Buffers returned instructions in a small queue and presents {if_pc, if_inst, if_valid} to IF/ID.
- Honours the ID stall and redirects on taken branches/jumps, discarding stale ROM responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction-queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- o_romReq  out  1  ROM request, registered.
- o_romAddr  out  32  ROM byte address, registered, bits[1:0] always 0.
- i_romAck  in  1  ROM acknowledge; i_romInst valid in the same cycle.
- i_romInst  in  32  instruction word from ROM.
- if_valid  out  1  queue head valid.
- if_pc  out  32  PC of queue head; 0 when empty.
- if_inst  out  32  instruction of queue head; 0 when empty.
- id_stall  in  1  ID cannot accept; head is held.
- br_taken  in  1  one-cycle redirect pulse from ID.
- br_target  in  32  redirect address.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, state=IDLE, o_romReq=0, o_romAddr=0, if_valid=0, if_pc=0, if_inst=0.
- States: IDLE, REQ, DROP.
- IDLE:
  - If queue count < FIFO_DEPTH: next edge o_romReq=1, o_romAddr=fetch_pc, go REQ.
  - The first request after reset release is issued on the first clock edge.
- REQ:
  - o_romReq and o_romAddr are held stable until i_romAck. ROM rule: a request is never withdrawn before its ack.
  - On ack: push {o_romAddr, i_romInst}; fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
  - If post-push, post-pop count < FIFO_DEPTH: stay REQ with o_romAddr=new fetch_pc (back-to-back, 1 instr/cycle max). Otherwise o_romReq=0, go IDLE.
- At most one ROM request outstanding; a queue slot is guaranteed whenever a request is issued.
- Output side:
  - if_valid = (count != 0); if_pc/if_inst come combinationally from the head entry.
  - Pop when if_valid && !id_stall.
  - Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (br_taken=1), highest priority:
  - Queue flushed; any pop that cycle is void.
  - fetch_pc = {br_target[31:2], 2'b00}.
  - Ack in the same cycle, or no request outstanding: data discarded, next edge o_romReq=1 at the new fetch_pc, state REQ.
  - Request outstanding without ack: go DROP.
- DROP:
  - Keep the old request asserted until ack; discard the data.
  - Next edge issue a request at fetch_pc, go REQ.
  - A second br_taken while in DROP only updates fetch_pc and stays DROP.
- if_valid goes 0 the cycle after a redirect and stays 0 until the first post-redirect ack.
- id_stall and a full queue never drop data. A held request at full count cannot occur.
- Reset mid-transaction: everything returns to reset values immediately; a late i_romAck is ignored in IDLE.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined:
  - Extra port if_bubble_cnt, out, 32 bits.
  - Counts cycles with rst=1 and if_valid=0, saturating at 32'hFFFF_FFFF.
  - Reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, ROM acks the cycle after each req, id_stall=0 -> o_romAddr 0x0, 0x4, 0x8 in order; if_pc follows 0x0, 0x4, 0x8 with matching if_inst; if_valid steady 1 after fill.
- id_stall=1 for 6 cycles with FIFO_DEPTH=2 -> exactly 2 entries buffered; o_romReq drops to 0; after release, heads 0x0, 0x4 then fetch resumes at 0x8 with no loss or duplication.
- br_taken with br_target=0x0000_0103 while a request is outstanding and no ack -> req stays at the old address until ack; that data is never seen on if_*; next request at 0x100; first valid if_pc=0x100.
- br_taken in the same cycle as i_romAck and an active pop -> acked data and head discarded; the next-cycle request is at the target; if_valid=0 for at least one cycle.
- RESET_PC=32'hFFFF_FFF8 -> fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted asynchronously mid-REQ -> o_romReq=0 and if_valid=0 before the next edge; with IF_PERF_CNT_EN, 3 empty cycles after release yield if_bubble_cnt=3.
